// File: rtl/reg_file_pkg.sv
// Shared widths for the integer register file, ALU and decode.
// Keeps operand and result widths consistent across the pipeline.
package reg_file_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] ZERO_REG = '0;

  function automatic logic is_arch(input logic [AW-1:0] a);
    return a != ZERO_REG;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: destination reservations, reserved-register
// count and the decode stall flag.
module reg_scoreboard
  import reg_file_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_addr,
  output logic          hazard,
  output logic [AW:0]   busy_cnt
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            wr_hit;
  logic            iss_hit;
  logic            inc;
  logic            dec;
  logic            haz1;
  logic            haz2;

  assign wr_hit  = wr_en && is_arch(rd_addr);
  assign iss_hit = issue_en && is_arch(issue_addr);

  // A new producer supersedes the one being written back.
  assign inc = iss_hit && !busy[issue_addr];
  assign dec = wr_hit && busy[rd_addr]
            && !(iss_hit && issue_addr == rd_addr);

  always_comb begin
    busy_nxt = busy;
    if (wr_hit)
      busy_nxt[rd_addr] = 1'b0;
    if (iss_hit)
      busy_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end

  assign haz1 = is_arch(rs1_addr) && busy[rs1_addr]
             && !(wr_en && rd_addr == rs1_addr);
  assign haz2 = is_arch(rs2_addr) && busy[rs2_addr]
             && !(wr_en && rd_addr == rs2_addr);

  assign hazard = haz1 || haz2;

endmodule

// File: rtl/reg_file.sv
// Integer register file with write-back bypass; sources ALU
// operands rs1/rs2 and sinks the ALU result rd.
module reg_file
  import reg_file_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  input  logic            wr_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_addr,
  output logic            hazard,
  output logic [AW:0]     busy_cnt
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_en && is_arch(rd_addr)) begin
      regs[rd_addr] <= rd;
    end
  end

  always_comb begin
    rs1 = regs[rs1_addr];
    if (!is_arch(rs1_addr))
      rs1 = '0;
    else if (wr_en && rd_addr == rs1_addr)
      rs1 = rd;
  end

  always_comb begin
    rs2 = regs[rs2_addr];
    if (!is_arch(rs2_addr))
      rs2 = '0;
    else if (wr_en && rd_addr == rs2_addr)
      rs2 = rd;
  end

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .wr_en      (wr_en),
    .rd_addr    (rd_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .hazard     (hazard),
    .busy_cnt   (busy_cnt)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus queues expected values,
// a negedge monitor pops and compares them.
module tb_reg_file;
  import reg_file_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            wr_en;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic            hazard;
  logic [AW:0]     busy_cnt;

  reg_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1        (rs1),
    .rs2        (rs2),
    .wr_en      (wr_en),
    .rd_addr    (rd_addr),
    .rd         (rd),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .hazard     (hazard),
    .busy_cnt   (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_RS1 = 0;
  localparam int S_RS2 = 1;
  localparam int S_HAZ = 2;
  localparam int S_CNT = 3;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;

  task automatic expect_v(input string nm, input int sel,
                          input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = v;
    q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RS1:   return rs1;
      S_RS2:   return rs2;
      S_HAZ:   return {31'd0, hazard};
      default: return {26'd0, busy_cnt};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = observe(e.sel);
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    issue_en = 1'b0;
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    rs1_addr   = '0;
    rs2_addr   = '0;
    wr_en      = 1'b0;
    rd_addr    = '0;
    rd         = '0;
    issue_en   = 1'b0;
    issue_addr = '0;

    step();
    rs1_addr = 5;
    expect_v("por_rs1", S_RS1, 32'h0);
    expect_v("por_haz", S_HAZ, 32'h0);
    expect_v("por_cnt", S_CNT, 32'h0);
    step();
    rst_n = 1'b1;

    // Populate r5, reserve r6, then reset mid-operation.
    step();
    wr_en = 1'b1; rd_addr = 5; rd = 32'h0000000A;
    issue_en = 1'b1; issue_addr = 6;
    step();
    idle();
    rs1_addr = 5; rs2_addr = 6;
    expect_v("pre_rst_rs1", S_RS1, 32'h0000000A);
    expect_v("pre_rst_cnt", S_CNT, 32'h1);
    expect_v("pre_rst_haz", S_HAZ, 32'h1);
    step();
    wr_en = 1'b1; rd_addr = 5; rd = 32'h00000055;
    issue_en = 1'b1; issue_addr = 8;
    rs1_addr = 0; rs2_addr = 0;
    #2 rst_n = 1'b0;
    step();
    idle();
    rs1_addr = 5; rs2_addr = 6;
    expect_v("in_rst_rs1", S_RS1, 32'h0);
    expect_v("in_rst_haz", S_HAZ, 32'h0);
    expect_v("in_rst_cnt", S_CNT, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    expect_v("post_rst_rs1", S_RS1, 32'h0);
    expect_v("post_rst_haz", S_HAZ, 32'h0);
    expect_v("post_rst_cnt", S_CNT, 32'h0);

    // x0 ignores writes and reservations, and never bypasses.
    step();
    wr_en = 1'b1; rd_addr = 0; rd = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_addr = 0;
    rs1_addr = 0; rs2_addr = 0;
    expect_v("x0_bypass", S_RS1, 32'h0);
    step();
    idle();
    expect_v("x0_rs1", S_RS1, 32'h0);
    expect_v("x0_cnt", S_CNT, 32'h0);
    expect_v("x0_haz", S_HAZ, 32'h0);

    step();
    wr_en = 1'b1; rd_addr = 1; rd = 32'h9D00A2AE;
    step();
    rd_addr = 2; rd = 32'h7B3729F4;
    step();
    idle();
    rs1_addr = 1; rs2_addr = 2;
    expect_v("wr_r1", S_RS1, 32'h9D00A2AE);
    expect_v("wr_r2", S_RS2, 32'h7B3729F4);

    step();
    wr_en = 1'b1; rd_addr = 3; rd = 32'hFFFFFFF6;
    rs1_addr = 1; rs2_addr = 3;
    expect_v("byp_rs2", S_RS2, 32'hFFFFFFF6);
    expect_v("byp_rs1_other", S_RS1, 32'h9D00A2AE);
    step();
    idle();
    expect_v("byp_stored", S_RS2, 32'hFFFFFFF6);

    // Reserve r7, observe stall, resolve through write-back.
    step();
    issue_en = 1'b1; issue_addr = 7;
    rs1_addr = 7; rs2_addr = 0;
    expect_v("iss7_haz_same", S_HAZ, 32'h0);
    step();
    idle();
    expect_v("iss7_cnt", S_CNT, 32'h1);
    expect_v("iss7_haz", S_HAZ, 32'h1);
    step();
    wr_en = 1'b1; rd_addr = 7; rd = 32'h14;
    expect_v("wb7_haz", S_HAZ, 32'h0);
    expect_v("wb7_rs1", S_RS1, 32'h14);
    expect_v("wb7_cnt_pre", S_CNT, 32'h1);
    step();
    idle();
    expect_v("wb7_cnt", S_CNT, 32'h0);
    expect_v("wb7_haz_after", S_HAZ, 32'h0);

    step();
    issue_en = 1'b1; issue_addr = 9;
    rs1_addr = 9;
    step();
    wr_en = 1'b1; rd_addr = 9; rd = 32'h11;
    expect_v("iw9_cnt_pre", S_CNT, 32'h1);
    expect_v("iw9_byp", S_RS1, 32'h11);
    expect_v("iw9_haz_byp", S_HAZ, 32'h0);
    step();
    idle();
    expect_v("iw9_cnt", S_CNT, 32'h1);
    expect_v("iw9_haz", S_HAZ, 32'h1);
    expect_v("iw9_rs1", S_RS1, 32'h11);

    // Issue r10 while retiring r9: net zero.
    step();
    issue_en = 1'b1; issue_addr = 10;
    wr_en = 1'b1; rd_addr = 9; rd = 32'h22;
    step();
    idle();
    rs1_addr = 9; rs2_addr = 10;
    expect_v("mix_cnt", S_CNT, 32'h1);
    expect_v("mix_rs1", S_RS1, 32'h22);
    expect_v("mix_haz_rs2", S_HAZ, 32'h1);

    // Issue r11 while writing idle r12: net +1.
    step();
    issue_en = 1'b1; issue_addr = 11;
    wr_en = 1'b1; rd_addr = 12; rd = 32'hCAFE0012;
    step();
    issue_en = 1'b1; issue_addr = 10;
    wr_en = 1'b0;
    rs1_addr = 12; rs2_addr = 0;
    expect_v("plus_cnt", S_CNT, 32'h2);
    expect_v("plus_rs1", S_RS1, 32'hCAFE0012);
    expect_v("plus_haz", S_HAZ, 32'h0);
    step();
    idle();
    rs1_addr = 0; rs2_addr = 11;
    expect_v("reiss_cnt", S_CNT, 32'h2);
    expect_v("reiss_haz", S_HAZ, 32'h1);

    begin
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 10) begin
        step();
        budget++;
      end
      if (q.size() > 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain: %0d left, expected 0", q.size());
      end
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
